// File: rtl/debug_command_engine.sv
// Serial debug command engine: decodes ping/read/write byte commands,
// runs one bus cycle with timeout, streams ACK/NAK/data bytes back.
//
// Ports:
//   comm_clock/comm_reset        clock, sync active-high reset
//   in_empty                     rx FIFO empty (status only)
//   in_valid/in_ready/in_data    command byte stream in
//   out_valid/out_ready/out_data response byte stream out
//   bus_request/bus_write/bus_addr/bus_wdata  bus master request
//   bus_ack/bus_rdata            bus completion and read data
//   busy                         engine not idle
module debug_command_engine #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  comm_clock,
  input  logic                  comm_reset,
  input  logic                  in_empty,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  bus_request,
  output logic                  bus_write,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  busy
);

  localparam int AB = ADDR_WIDTH / 8;
  localparam int DB = DATA_WIDTH / 8;
  localparam int OW = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_OPERAND = 2'd1;
  localparam logic [1:0] S_EXECUTE = 2'd2;
  localparam logic [1:0] S_RESPOND = 2'd3;

  localparam logic [7:0] CMD_PING  = 8'h50;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  logic [1:0]            state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_q, wr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [OW-1:0]         opnd_q, opnd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  bwr_q, bwr_d;
  logic [15:0]           timer_q, timer_d;
  logic [DATA_WIDTH-1:0] resp_q, resp_d;
  logic [2:0]            rcnt_q, rcnt_d;
  logic                  in_fire;
  logic                  unused_in_empty;

  assign unused_in_empty = in_empty;
  assign in_fire = in_valid && in_ready_q;

  // Response bytes leave from the top of resp_q, so a
  // single-byte reply is parked in the top byte.
  function automatic logic [DATA_WIDTH-1:0] top_byte(
    input logic [7:0] b
  );
    return DATA_WIDTH'(b) << (DATA_WIDTH - 8);
  endfunction

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bwr_d   = bwr_q;
    timer_d = timer_q;
    resp_d  = resp_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          opnd_d = '0;
          case (in_data)
            CMD_PING: begin
              resp_d  = top_byte(RSP_ACK);
              rcnt_d  = 3'd1;
              state_d = S_RESPOND;
            end
            CMD_READ: begin
              wr_d    = 1'b0;
              cnt_d   = 4'(AB);
              state_d = S_OPERAND;
            end
            CMD_WRITE: begin
              wr_d    = 1'b1;
              cnt_d   = 4'(AB + DB);
              state_d = S_OPERAND;
            end
            default: begin
              resp_d  = top_byte(RSP_NAK);
              rcnt_d  = 3'd1;
              state_d = S_RESPOND;
            end
          endcase
        end
      end
      S_OPERAND: begin
        if (in_fire) begin
          opnd_d = {opnd_q[OW-9:0], in_data};
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            // Read: address in low bytes.
            // Write: address above the data.
            addr_d  = wr_q ? opnd_d[OW-1 -: ADDR_WIDTH]
                           : opnd_d[ADDR_WIDTH-1:0];
            wdata_d = opnd_d[DATA_WIDTH-1:0];
            bwr_d   = wr_q;
            timer_d = '0;
            state_d = S_EXECUTE;
          end
        end
      end
      S_EXECUTE: begin
        // Ack is checked first so it wins on the last cycle.
        if (bus_ack) begin
          if (wr_q) begin
            resp_d = top_byte(RSP_ACK);
            rcnt_d = 3'd1;
          end else begin
            resp_d = bus_rdata;
            rcnt_d = 3'(DB);
          end
          state_d = S_RESPOND;
        end else if (timer_q == 16'(TIMEOUT - 1)) begin
          resp_d  = top_byte(RSP_NAK);
          rcnt_d  = 3'd1;
          state_d = S_RESPOND;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_RESPOND: begin
        if (out_ready) begin
          resp_d = resp_q << 8;
          rcnt_d = rcnt_q - 3'd1;
          if (rcnt_q == 3'd1) state_d = S_IDLE;
        end
      end
    endcase
    in_ready_d = (state_d == S_IDLE) ||
                 (state_d == S_OPERAND);
  end

  always_ff @(posedge comm_clock) begin
    if (comm_reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      opnd_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bwr_q      <= 1'b0;
      timer_q    <= '0;
      resp_q     <= '0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bwr_q      <= bwr_d;
      timer_q    <= timer_d;
      resp_q     <= resp_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q == S_RESPOND);
  assign out_data    = resp_q[DATA_WIDTH-1 -: 8];
  assign bus_request = (state_q == S_EXECUTE);
  assign bus_write   = bwr_q;
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/debug_command_engine.md
Name: debug_command_engine

Overview:
Parametrised successor to the single-state serial debug controller. Consumes command and operand bytes from the receive FIFO, decodes ping/read/write commands, and drives a simple request/acknowledge bus-master port with a bounded timeout. Returns acknowledge, data or error bytes through a transmit byte stream. Sits between the UART FIFOs and the bus under debug, in the comm_clock domain.

Parameters:
ADDR_WIDTH, 24, bus address width in bits; must be a multiple of 8, 8..32
DATA_WIDTH, 16, bus data width in bits; must be a multiple of 8, 8..32
TIMEOUT, 255, maximum cycles to wait for bus_ack before aborting; 1..65535

Ports:
comm_clock  input  1  sole clock; all logic on the rising edge
comm_reset  input  1  synchronous, active-high reset
in_empty  input  1  receive FIFO empty flag; status only, never gates a transfer
in_ready  output  1  engine can accept a byte this cycle
in_valid  input  1  in_data holds a valid byte
in_data  input  8  received byte
out_valid  output  1  out_data holds a response byte
out_ready  input  1  transmitter accepts the byte
out_data  output  8  response byte
bus_request  output  1  bus cycle requested
bus_write  output  1  1 = write, 0 = read; valid while bus_request is high
bus_addr  output  ADDR_WIDTH  bus address
bus_wdata  output  DATA_WIDTH  write data
bus_ack  input  1  bus cycle complete; bus_rdata valid this cycle
bus_rdata  input  DATA_WIDTH  read data
busy  output  1  high in every state except IDLE

Behaviour:
- One clock (comm_clock). Reset is synchronous and active-high (comm_reset).
- Reset values: state IDLE, in_ready 0, out_valid 0, out_data 0x00, bus_request 0, bus_write 0, bus_addr 0, bus_wdata 0, busy 0. in_ready rises on the first cycle after reset is released.
- Input transfer: a byte is consumed on an edge where in_valid and in_ready are both high. in_ready is high only in IDLE and OPERAND.
- Output transfer: a byte is consumed on an edge where out_valid and out_ready are both high. out_data stays stable while out_valid is high and out_ready is low.
- Let AB = ADDR_WIDTH/8 and DB = DATA_WIDTH/8.
- Commands:
  - 0x50 'P' ping: 0 operands, no bus cycle, response 0x06.
  - 0x52 'R' read: AB address bytes, MSB first. Response is DB data bytes, MSB first.
  - 0x57 'W' write: AB address bytes, then DB data bytes, each MSB first. Response 0x06.
  - Any other byte: response 0x15 (NAK), no bus cycle, no operands consumed.
- States:
  - IDLE: on a transfer, latch the command and load the operand counter. Go to OPERAND if the count is >0, else RESPOND.
  - OPERAND: each transfer shifts the byte into the address/data register and decrements the counter. After the last byte, go to EXECUTE. There is no inter-byte timeout.
  - EXECUTE: bus_request goes high on the first cycle in this state and bus_addr/bus_wdata/bus_write are held stable. The timer starts at 0 and increments each cycle bus_ack is low.
    - bus_ack high: capture bus_rdata, drop bus_request on the next edge, go to RESPOND with an ACK or data response.
    - Timer reaches TIMEOUT: drop bus_request, go to RESPOND with a single 0x15.
    - bus_ack on the same cycle the timer reaches TIMEOUT: the ack wins.
  - RESPOND: out_valid is high. The response byte index advances on each output transfer. After the last byte, go to IDLE and deassert out_valid on the same edge.
- Minimum latency, ping: command accepted at edge N; out_valid high from edge N+1.
- Minimum latency, read/write with zero-wait ack: bus_request high the cycle after the last operand; response begins the cycle after the ack.
- bus_ack while bus_request is low is ignored.
- comm_reset in any state returns all outputs to their reset values on that edge. A partial command is discarded, a pending bus cycle is abandoned (bus_request low after the edge), and an unsent response is dropped.

Test Plan:
- Reset, then send 0x50 with out_ready=1 -> one byte 0x06, busy returns low, bus_request never asserted.
- Send 0x57, 00 12 34, BE EF (defaults) with bus_ack one cycle after request -> bus_write=1, bus_addr=0x001234, bus_wdata=0xBEEF held until ack; response 0x06.
- Send 0x52, 00 00 10 with bus_rdata=0xA55A acked after 3 cycles and out_ready toggling -> bytes 0xA5 then 0x5A, each held stable while out_ready is low.
- Send a read with bus_ack tied low (TIMEOUT=255) -> bus_request high for exactly 255 cycles then low; response 0x15; the next ping is answered 0x06.
- Send 0x3F -> 0x15; follow-up 0x50 -> 0x06. Separately, send a write, gap in_valid mid-operands, assert comm_reset after 2 operand bytes -> all outputs at reset values; a fresh ping succeeds.
